m_unit_controller: RTL and testbench

Multi-cycle sequencer for the RV32M extension, sitting beside the execute stage. It receives M-type operations, which use the execute stage's forwarded operands, and runs them through one shared multiplier and an internal radix-2 iterative divider. While the operation is in flight it holds the pipeline with `stall`, then presents the rd write value for one cycle. It is the only owner of the multiply/divide resource; the ALU path never handles M-type instructions.

---
 rtl/m_unit_controller_if.sv | 25 ++
 rtl/m_unit_controller.sv | 167 ++++++++++++++++
 tb/tb_m_unit_controller.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_unit_controller_if.sv
// Handshake between the execute stage and the M-extension sequencer.
// The EX side is the master; the multiply/divide unit is the slave.
interface m_unit_controller_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, func3, op1, op2,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  start, flush, func3, op1, op2,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/m_unit_controller.sv
// RV32M sequencer: single-cycle shared multiplier plus a 32-step restoring divider.
// Holds the pipeline with stall while busy and pulses result_valid in DONE.
module m_unit_controller #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    m_unit_controller_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] op_a_reg, op_b_reg;
    logic [2:0]      func3_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, div_reg;
    logic            neg_q_reg, neg_r_reg;
    logic [XLEN-1:0] result_reg;

    // Launch decode, evaluated on the live EX operands
    logic            accept;
    logic            in_signed;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] a_mag, b_mag;

    assign accept    = (state_reg == ST_IDLE) && bus.start && !bus.flush;
    assign in_signed = !bus.func3[0];
    assign div_zero  = (bus.op2 == '0);
    assign overflow  = in_signed && (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
    assign a_mag     = (in_signed && bus.op1[XLEN-1]) ? (-bus.op1) : bus.op1;
    assign b_mag     = (in_signed && bus.op2[XLEN-1]) ? (-bus.op2) : bus.op2;

    // Multiplier: sign-extend each operand to 2*XLEN as the variant requires
    logic            mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] a_wide, b_wide, product;

    assign mul_a_signed = (func3_reg != 3'd3);
    assign mul_b_signed = (func3_reg == 3'd0) || (func3_reg == 3'd1);
    assign a_wide  = {{XLEN{mul_a_signed & op_a_reg[XLEN-1]}}, op_a_reg};
    assign b_wide  = {{XLEN{mul_b_signed & op_b_reg[XLEN-1]}}, op_b_reg};
    assign product = a_wide * b_wide;

    // One restoring-division step on the magnitudes
    logic [XLEN:0]   rem_shift, trial;
    logic [XLEN-1:0] rem_step, quo_step, div_result;

    always_comb begin
        rem_shift = {rem_reg, quo_reg[XLEN-1]};
        trial     = rem_shift - {1'b0, div_reg};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b0};
        end
        if (func3_reg[1]) begin
            div_result = neg_r_reg ? (-rem_step) : rem_step;
        end else begin
            div_result = neg_q_reg ? (-quo_step) : quo_step;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (!bus.func3[2]) begin
                        state_next = ST_MUL;
                    end else if (div_zero || overflow) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DIV;
                    end
                end
            end
            ST_MUL:  state_next = bus.flush ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (count_reg == LAST_STEP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            func3_reg  <= '0;
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            div_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_reg  <= bus.op1;
                        op_b_reg  <= bus.op2;
                        func3_reg <= bus.func3;
                        count_reg <= '0;
                        rem_reg   <= '0;
                        quo_reg   <= a_mag;
                        div_reg   <= b_mag;
                        neg_q_reg <= in_signed && (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
                        neg_r_reg <= in_signed && bus.op1[XLEN-1];
                        // Special divides resolve here and skip the iteration
                        if (bus.func3[2] && div_zero) begin
                            result_reg <= bus.func3[1] ? bus.op1 : '1;
                        end else if (bus.func3[2] && overflow) begin
                            result_reg <= bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end
                    end
                end
                ST_MUL: begin
                    if (!bus.flush) begin
                        result_reg <= (func3_reg == 3'd0) ? product[XLEN-1:0]
                                                          : product[2*XLEN-1:XLEN];
                    end
                end
                ST_DIV: begin
                    if (!bus.flush) begin
                        rem_reg   <= rem_step;
                        quo_reg   <= quo_step;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_STEP) begin
                            result_reg <= div_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall        = accept || (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.result_valid = (state_reg == ST_DONE);
    assign bus.result       = result_reg;
endmodule

// File: tb/tb_m_unit_controller.sv
// Self-checking bench for m_unit_controller: directed RV32M cases, random operations,
// flush, back-to-back and mid-operation reset against an arithmetic reference model.
module tb_m_unit_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] last_result;

    m_unit_controller_if bus ();

    m_unit_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed with 64-bit arithmetic straight from the RV32M rules
    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, ua, ub, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'd0: begin t = sa * sb; p = t; return p[31:0]; end
            3'd1: begin t = sa * sb; p = t; return p[63:32]; end
            3'd2: begin t = sa * ub; p = t; return p[63:32]; end
            3'd3: begin t = ua * ub; p = t; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                t = sa / sb; p = t; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                t = ua / ub; p = t; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                t = sa % sb; p = t; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                t = ua % ub; p = t; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
        if (f < 3'd4) return 2;
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Launch one operation in the current cycle and follow it to completion
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int k;
        bit stall_bad;
        logic [31:0] exp_r;
        int exp_l;
        exp_r = model_result(f, a, b);
        exp_l = model_latency(f, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b0; bus.func3 = f; bus.op1 = a; bus.op2 = b;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL launch_stall f3=%0d got %b want 1", f, bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.func3 = 3'($urandom); bus.op1 = $urandom; bus.op2 = $urandom;
        stall_bad = 1'b0;
        k = 1;
        while (k <= 40 && bus.result_valid !== 1'b1) begin
            if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k > 40) begin
            errors++; $display("FAIL timeout f3=%0d a=%h b=%h no result_valid", f, a, b);
        end
        checks++;
        if (k != exp_l) begin
            errors++; $display("FAIL latency f3=%0d a=%h b=%h got %0d want %0d", f, a, b, k, exp_l);
        end
        checks++;
        if (stall_bad) begin
            errors++; $display("FAIL busy_stall f3=%0d stall/busy dropped before DONE", f);
        end
        checks++;
        if (bus.result !== exp_r) begin
            errors++; $display("FAIL result f3=%0d a=%h b=%h got %h want %h", f, a, b, bus.result, exp_r);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL done_stall f3=%0d got %b want 0", f, bus.stall);
        end
        last_result = exp_r;
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.result !== exp_r) begin
            errors++; $display("FAIL after_done valid=%b result=%h want 0/%h", bus.result_valid, bus.result, exp_r);
        end
        $display("op f3=%0d a=%h b=%h result=%h latency=%0d", f, a, b, bus.result, k);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0; bus.op1 = '0; bus.op2 = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset stall=%b busy=%b valid=%b result=%h want 0/0/0/0",
                     bus.stall, bus.busy, bus.result_valid, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_result = 32'd0;
        $display("reset released");
    endtask

    task automatic test_mul();
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
    endtask

    task automatic test_edge_divides();
        do_op(3'd5, 32'd1234, 32'd0);
        do_op(3'd7, 32'd5, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd4, 32'hDEAD_BEEF, 32'd0);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  f;
        int sel;
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 20));
            do_op(f, a, b);
        end
    endtask

    task automatic test_flush();
        bit saw_valid;
        // flush together with start in IDLE: nothing launches
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd5; bus.op1 = 32'd9; bus.op2 = 32'd3;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_idle_stall got %b want 0", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_busy got %b want 0", bus.busy);
        end
        // flush in the middle of a divide
        bus.start = 1'b1; bus.func3 = 3'd4; bus.op1 = $urandom; bus.op2 = $urandom | 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_div_idle busy=%b stall=%b want 0/0", bus.busy, bus.stall);
        end
        checks++;
        if (bus.result !== last_result) begin
            errors++; $display("FAIL flush_div_result got %h want %h", bus.result, last_result);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++; $display("FAIL flush_div_valid got pulse want none");
        end
        $display("flush mid-divide result=%h", bus.result);
        // flush in MUL
        @(negedge clk);
        bus.start = 1'b1; bus.func3 = 3'd0; bus.op1 = 32'd7; bus.op2 = 32'd6;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== last_result) begin
            errors++;
            $display("FAIL flush_mul valid=%b busy=%b result=%h want 0/0/%h",
                     bus.result_valid, bus.busy, bus.result, last_result);
        end
        $display("flush mid-multiply result=%h", bus.result);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int pulses;
        int t1, t2;
        logic [31:0] r1, r2;
        a1 = $urandom; b1 = $urandom_range(1, 32'hFFFF);
        a2 = $urandom; b2 = $urandom | 32'd1;
        pulses = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b0; bus.func3 = 3'd5; bus.op1 = a1; bus.op2 = b1;
        @(negedge clk);
        bus.op1 = a2; bus.op2 = b2;
        for (int k = 1; k <= 80; k++) begin
            if (bus.result_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin t1 = k; r1 = bus.result; end
                if (pulses == 2) begin t2 = k; r2 = bus.result; end
                checks++;
                if (bus.stall !== 1'b0) begin
                    errors++; $display("FAIL b2b_done_stall got %b want 0", bus.stall);
                end
            end
            if (k == 35) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL b2b_pulses got %0d want 2", pulses);
        end
        checks++;
        if (t1 != 33 || t2 != 67) begin
            errors++; $display("FAIL b2b_timing got %0d,%0d want 33,67", t1, t2);
        end
        checks++;
        if (r1 !== model_result(3'd5, a1, b1) || r2 !== model_result(3'd5, a2, b2)) begin
            errors++;
            $display("FAIL b2b_results got %h,%h want %h,%h", r1, r2,
                     model_result(3'd5, a1, b1), model_result(3'd5, a2, b2));
        end
        last_result = model_result(3'd5, a2, b2);
        $display("back-to-back DIVU results=%h,%h at %0d,%0d", r1, r2, t1, t2);
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b0; bus.func3 = 3'd6; bus.op1 = $urandom; bus.op2 = $urandom | 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b stall=%b valid=%b result=%h want 0/0/0/0",
                     bus.busy, bus.stall, bus.result_valid, bus.result);
        end
        last_result = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++; $display("FAIL reset_mid_valid got pulse want none");
        end
        $display("reset mid-divide aborted");
        do_op(3'd4, 32'hFFFF_FF9C, 32'd7);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_result = 32'd0;
        test_reset();
        test_mul();
        test_div();
        test_edge_divides();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
